// File: rtl/prog_ram_pkg.sv
// ============================================================================
// Module : prog_ram_pkg
// Brief  : Shared types and width defaults for the program-RAM arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package prog_ram_pkg;

    localparam int c_DWIDTH = 16;
    localparam int c_AWIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_HOST = 1'b1
    } gnt_e;

endpackage

`default_nettype wire

// File: rtl/prog_ram_arbiter_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter; bit 0 = CPU, bit 1 = host.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import prog_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    gnt_e last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == GNT_CPU) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // Starting from HOST lets the CPU win the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GNT_HOST;
        end else if (adv_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[0] ? GNT_CPU : GNT_HOST;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_ram_arbiter.sv
// ============================================================================
// Module : prog_ram_arbiter
// Brief  : Shares the synchronous-read program RAM between CPU fetch and host.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module prog_ram_arbiter
    import prog_ram_pkg::*;
#(
    parameter int DWIDTH = c_DWIDTH,
    parameter int AWIDTH = c_AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [AWIDTH-1:0] cpu_addr,
    output logic              cpu_rvalid,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_en,
    output logic              cpu_overrun,
    input  logic              host_lock,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    output logic              host_ack,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata
);

    state_e            state_q,      state_d;
    gnt_e              owner_q,      owner_d;
    logic              cpu_pend_q,   cpu_pend_d;
    logic [AWIDTH-1:0] cpu_addr_q,   cpu_addr_d;
    logic              overrun_q,    overrun_d;
    logic              cpu_en_q;
    logic              ram_en_q,     ram_en_d;
    logic              ram_we_q,     ram_we_d;
    logic [AWIDTH-1:0] ram_addr_q,   ram_addr_d;
    logic [DWIDTH-1:0] ram_wdata_q,  ram_wdata_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [DWIDTH-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic              host_ack_q,   host_ack_d;
    logic [DWIDTH-1:0] host_rdata_q, host_rdata_d;

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_adv;
    logic       w_cpu_grant;

    // A host whose ack is on the wire this cycle is still holding req; mask it.
    assign w_req = {host_req & ~host_ack_q, cpu_pend_q & ~host_lock};

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .req_i (w_req & {2{state_q == IDLE}}),
        .adv_i (w_adv),
        .gnt_o (w_gnt)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        w_adv        = 1'b0;
        w_cpu_grant  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_gnt != 2'b00) begin
                    w_adv    = 1'b1;
                    ram_en_d = 1'b1;
                    state_d  = ISSUE;
                    if (w_gnt[0]) begin
                        w_cpu_grant = 1'b1;
                        owner_d     = GNT_CPU;
                        ram_addr_d  = cpu_addr_q;
                    end else begin
                        owner_d     = GNT_HOST;
                        ram_we_d    = host_we;
                        ram_addr_d  = host_addr;
                        ram_wdata_d = host_wdata;
                    end
                end
            end
            ISSUE: begin
                if (ram_we_q) begin
                    host_ack_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (owner_q == GNT_CPU) begin
                    cpu_rvalid_d = 1'b1;
                    cpu_rdata_d  = ram_rdata;
                end else begin
                    host_ack_d   = 1'b1;
                    host_rdata_d = ram_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A fetch pulse landing on the grant cycle opens a fresh pending slot.
    always_comb begin
        cpu_pend_d = cpu_pend_q & ~w_cpu_grant;
        cpu_addr_d = cpu_addr_q;
        overrun_d  = overrun_q;
        if (cpu_req) begin
            if (!cpu_pend_q || w_cpu_grant) begin
                cpu_pend_d = 1'b1;
                cpu_addr_d = cpu_addr;
            end else begin
                overrun_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= GNT_HOST;
            cpu_pend_q   <= 1'b0;
            cpu_addr_q   <= '0;
            overrun_q    <= 1'b0;
            cpu_en_q     <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_addr_q   <= cpu_addr_d;
            overrun_q    <= overrun_d;
            cpu_en_q     <= ~host_lock;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_en      = cpu_en_q;
    assign cpu_overrun = overrun_q;
    assign host_ack    = host_ack_q;
    assign host_rdata  = host_rdata_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_ram_arbiter.sv
// ============================================================================
// Module : tb_prog_ram_arbiter
// Brief  : Scoreboard bench for prog_ram_arbiter with a synchronous RAM model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_prog_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        cpu_en;
    logic        cpu_overrun;
    logic        host_lock = 1'b0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [15:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] data;
    } host_exp_t;

    logic [15:0] cpu_q[$];
    host_exp_t   host_q[$];
    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    prog_ram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .cpu_en      (cpu_en),
        .cpu_overrun (cpu_overrun),
        .host_lock   (host_lock),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    // Scoreboard: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_rvalid) begin
                checks++;
                if (cpu_q.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_rvalid_unexpected data=%h", cpu_rdata);
                end else begin
                    logic [15:0] e;
                    e = cpu_q.pop_front();
                    if (cpu_rdata !== e) begin
                        errors++;
                        $display("FAIL cpu_rdata got=%h exp=%h", cpu_rdata, e);
                    end
                end
            end
            if (host_ack) begin
                checks++;
                if (host_q.size() == 0) begin
                    errors++;
                    $display("FAIL host_ack_unexpected");
                end else begin
                    host_exp_t h;
                    h = host_q.pop_front();
                    if (!h.we && host_rdata !== h.data) begin
                        errors++;
                        $display("FAIL host_rdata got=%h exp=%h", host_rdata, h.data);
                    end
                end
            end
        end
    end

    // Host side drops its request as soon as it sees the ack.
    task tick();
        @(posedge clk);
        #1;
        if (host_ack) host_req = 1'b0;
    endtask

    task do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task wait_ram_en(output logic [15:0] a, output logic we, output logic ok);
        ok = 1'b0;
        a  = '0;
        we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ram_en) begin
                a  = ram_addr;
                we = ram_we;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cpu_q.size() == 0 && host_q.size() == 0 && !host_req) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain cpu_pending=%0d host_pending=%0d required=0",
                     name, cpu_q.size(), host_q.size());
            cpu_q.delete();
            host_q.delete();
            host_req = 1'b0;
        end
        tick();
        tick();
    endtask

    task host_start(input logic we, input logic [15:0] a, input logic [15:0] d);
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        host_req   = 1'b1;
    endtask

    task test_reset();
        checks++;
        if ({cpu_rvalid, cpu_en, cpu_overrun, host_ack, ram_en, ram_we} !== 6'b0 ||
            cpu_rdata !== 16'h0 || host_rdata !== 16'h0 || ram_addr !== 16'h0 || ram_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_state outputs not all zero (ram_addr=%h cpu_en=%b)", ram_addr, cpu_en);
        end
        do_reset();
        tick();
        cpu_req  = 1'b1;
        cpu_addr = 16'h0010;
        tick();
        cpu_req  = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cpu_rvalid, cpu_en, cpu_overrun, host_ack, ram_en, ram_we} !== 6'b0 ||
            ram_addr !== 16'h0 || cpu_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_async got ram_addr=%h cpu_en=%b ram_en=%b required 0",
                     ram_addr, cpu_en, ram_en);
        end
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_cpu_en_lag got=%b exp=0", cpu_en);
        end
        tick();
        checks++;
        if (cpu_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_cpu_en_rise got=%b exp=1", cpu_en);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ram_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_dropped_access ram_en got=%b exp=0", ram_en);
            end
        end
    endtask

    task test_cpu_fetch();
        cpu_req  = 1'b1;
        cpu_addr = 16'h0004;
        cpu_q.push_back(16'hA5C3);
        tick();
        cpu_req  = 1'b0;
        cpu_addr = 16'hFFFF;
        tick();
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'h0004) begin
            errors++;
            $display("FAIL fetch_issue got en=%b we=%b addr=%h exp 1 0 0004", ram_en, ram_we, ram_addr);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b0 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait got rvalid=%b en=%b exp 0 0", cpu_rvalid, ram_en);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hA5C3) begin
            errors++;
            $display("FAIL fetch_latency got rvalid=%b data=%h exp 1 a5c3", cpu_rvalid, cpu_rdata);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hA5C3) begin
            errors++;
            $display("FAIL fetch_hold got rvalid=%b data=%h exp 0 a5c3", cpu_rvalid, cpu_rdata);
        end
        wait_drain("fetch");
    endtask

    task test_host_wr_rd();
        host_start(1'b1, 16'h0020, 16'h1234);
        host_q.push_back('{we: 1'b1, data: 16'h0});
        tick();
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'h0020 || ram_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL host_write_issue got en=%b we=%b addr=%h wdata=%h", ram_en, ram_we, ram_addr, ram_wdata);
        end
        tick();
        checks++;
        if (host_ack !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL host_write_ack got ack=%b we=%b exp 1 0", host_ack, ram_we);
        end
        tick();
        checks++;
        if (host_ack !== 1'b0 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL host_ack_pulse got ack=%b en=%b exp 0 0", host_ack, ram_en);
        end
        host_start(1'b0, 16'h0020, 16'h0000);
        host_q.push_back('{we: 1'b0, data: 16'h1234});
        tick();
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'h0020) begin
            errors++;
            $display("FAIL host_read_issue got en=%b we=%b addr=%h", ram_en, ram_we, ram_addr);
        end
        tick();
        checks++;
        if (host_ack !== 1'b0) begin
            errors++;
            $display("FAIL host_read_early got ack=%b exp 0", host_ack);
        end
        tick();
        checks++;
        if (host_ack !== 1'b1 || host_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL host_read_data got ack=%b data=%h exp 1 1234", host_ack, host_rdata);
        end
        wait_drain("host");
    endtask

    task tie(input logic [15:0] first_exp, input logic [15:0] second_exp, input string name);
        logic [15:0] a;
        logic        we;
        logic        ok;
        cpu_req  = 1'b1;
        cpu_addr = 16'h0001;
        cpu_q.push_back(16'h1111);
        tick();
        cpu_req = 1'b0;
        host_start(1'b0, 16'h0002, 16'h0000);
        host_q.push_back('{we: 1'b0, data: 16'h2222});
        wait_ram_en(a, we, ok);
        checks++;
        if (!ok || a !== first_exp) begin
            errors++;
            $display("FAIL %s_first got ok=%b addr=%h exp %h", name, ok, a, first_exp);
        end
        wait_ram_en(a, we, ok);
        checks++;
        if (!ok || a !== second_exp) begin
            errors++;
            $display("FAIL %s_second got ok=%b addr=%h exp %h", name, ok, a, second_exp);
        end
        wait_drain(name);
    endtask

    task test_tie();
        do_reset();
        tick();
        tie(16'h0001, 16'h0002, "tie1");
        cpu_req  = 1'b1;
        cpu_addr = 16'h0004;
        cpu_q.push_back(16'hA5C3);
        tick();
        cpu_req = 1'b0;
        wait_drain("tie_solo");
        tie(16'h0002, 16'h0001, "tie2");
    endtask

    task test_lock();
        logic [15:0] a;
        logic        we;
        logic        ok;
        host_lock = 1'b1;
        cpu_req   = 1'b1;
        cpu_addr  = 16'h0008;
        tick();
        cpu_req = 1'b0;
        checks++;
        if (cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL lock_cpu_en got=%b exp=0", cpu_en);
        end
        host_start(1'b1, 16'h0030, 16'hBEEF);
        host_q.push_back('{we: 1'b1, data: 16'h0});
        wait_ram_en(a, we, ok);
        checks++;
        if (!ok || a !== 16'h0030 || we !== 1'b1) begin
            errors++;
            $display("FAIL lock_host_write got ok=%b addr=%h we=%b exp 1 0030 1", ok, a, we);
        end
        wait_drain("lock_host");
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ram_en !== 1'b0) begin
                errors++;
                $display("FAIL lock_blocks_cpu ram_en got=%b exp=0", ram_en);
            end
        end
        host_lock = 1'b0;
        cpu_q.push_back(16'h8888);
        wait_ram_en(a, we, ok);
        checks++;
        if (!ok || a !== 16'h0008 || cpu_en !== 1'b1) begin
            errors++;
            $display("FAIL lock_release got ok=%b addr=%h cpu_en=%b exp 1 0008 1", ok, a, cpu_en);
        end
        wait_drain("lock_cpu");
    endtask

    task test_overrun();
        logic [15:0] a;
        logic        we;
        logic        ok;
        host_lock = 1'b1;
        cpu_req   = 1'b1;
        cpu_addr  = 16'h0003;
        tick();
        cpu_req = 1'b0;
        checks++;
        if (cpu_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early got=%b exp=0", cpu_overrun);
        end
        tick();
        cpu_req  = 1'b1;
        cpu_addr = 16'h0005;
        tick();
        cpu_req = 1'b0;
        checks++;
        if (cpu_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got=%b exp=1", cpu_overrun);
        end
        host_lock = 1'b0;
        cpu_q.push_back(16'h3333);
        wait_ram_en(a, we, ok);
        checks++;
        if (!ok || a !== 16'h0003) begin
            errors++;
            $display("FAIL overrun_addr got ok=%b addr=%h exp 1 0003", ok, a);
        end
        wait_drain("overrun");
        checks++;
        if (cpu_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got=%b exp=1", cpu_overrun);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h01] = 16'h1111;
        mem[8'h02] = 16'h2222;
        mem[8'h03] = 16'h3333;
        mem[8'h04] = 16'hA5C3;
        mem[8'h05] = 16'h5555;
        mem[8'h08] = 16'h8888;
        mem[8'h10] = 16'h1010;
        #1;
        test_reset();
        test_cpu_fetch();
        test_host_wr_rd();
        test_tie();
        test_lock();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
